mat_result_streamer: RTL and testbench

//  Drain side of the matrix-multiply engine. Captures one wide N*N*W_OUT result
//  bus on a valid pulse and streams it out LANES elements per beat. Output is a

---
 rtl/mat_result_streamer_pkg.sv | 25 ++
 rtl/mat_result_streamer.sv | 121 ++++++++++++
 tb/tb_mat_result_streamer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mat_result_streamer_pkg.sv
// Shared sizing helpers and state encoding for the matrix result path.
// The operand loader is expected to import this package as well.
package mat_result_streamer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Number of elements in an n x n matrix.
  function automatic int mat_elems(input int n);
    return n * n;
  endfunction

  // Output beats needed to move one matrix, lanes elements at a time.
  function automatic int mat_beats(input int n, input int lanes);
    return (n * n) / lanes;
  endfunction

  // Beat counter width; never narrower than one bit.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mat_result_streamer.sv
// Drain side of the matrix-multiply engine: captures one N*N result matrix on
// a valid pulse and streams it out LANES elements per beat on a valid/ready
// interface. Results arriving while busy are dropped and flagged as overflow.
module mat_result_streamer
  import mat_result_streamer_pkg::*;
#(
  parameter int W_OUT = 32,
  parameter int N     = 8,
  parameter int LANES = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     valid_in,
  input  logic [N*N*W_OUT-1:0]     result,
  output logic                     in_ready,
  output logic                     m_valid,
  output logic [LANES*W_OUT-1:0]   m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  input  logic                     ovf_clr,
  output logic                     overflow
);

  localparam int ELEMS   = mat_elems(N);
  localparam int BEATS   = mat_beats(N, LANES);
  localparam int CNT_W   = cnt_width(BEATS);
  localparam int SLICE_W = LANES * W_OUT;
  localparam int BUF_W   = ELEMS * W_OUT;

  // A lane count that does not tile the matrix would leave a ragged last beat.
  if (ELEMS % LANES != 0) begin : g_bad_lanes
    $error("mat_result_streamer: LANES must divide N*N");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BUF_W-1:0]   buffer_q;
  logic               overflow_q;
  logic               load;
  logic               last_beat;
  logic               handshake;
  logic               drop;

  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign m_valid   = (state_q == ST_STREAM);
  assign m_last    = m_valid & last_beat;
  assign handshake = m_valid & m_ready;
  // The only combinational input-to-output path: a finishing beat frees the buffer.
  assign in_ready  = (state_q == ST_IDLE) | (handshake & last_beat);
  assign drop      = valid_in & ~in_ready;
  assign m_data    = buffer_q[int'(beat_cnt_q) * SLICE_W +: SLICE_W];
  assign overflow  = overflow_q;

  // Next-state, beat counter and capture decision.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    load       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          load       = 1'b1;
          beat_cnt_d = '0;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (handshake) begin
          if (!last_beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else if (valid_in) begin
            load       = 1'b1;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!resetn) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Capture buffer holding the matrix being streamed.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: this wide buffer is reset on purpose so m_data reads zero out of
    // reset; plain storage arrays would normally be left unreset.
    if (!resetn) begin
      buffer_q <= '0;
    end else if (load) begin
      buffer_q <= result;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mat_result_streamer.sv
// Self-checking bench: two instances (LANES=1 and LANES=4) share stimulus and
// are compared each cycle against a queue-based model of pending elements.
module tb_mat_result_streamer;

  localparam int W = 32;
  localparam int N = 8;
  localparam int E = N * N;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             valid_in = 1'b0;
  logic             m_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [E*W-1:0]   result = '0;

  logic             in_ready1, m_valid1, m_last1, overflow1;
  logic [W-1:0]     m_data1;
  logic             in_ready4, m_valid4, m_last4, overflow4;
  logic [4*W-1:0]   m_data4;

  always #5 clk = ~clk;

  mat_result_streamer #(.W_OUT(W), .N(N), .LANES(1)) dut1 (
    .clk(clk), .resetn(resetn), .valid_in(valid_in), .result(result),
    .in_ready(in_ready1), .m_valid(m_valid1), .m_data(m_data1), .m_last(m_last1),
    .m_ready(m_ready), .ovf_clr(ovf_clr), .overflow(overflow1)
  );

  mat_result_streamer #(.W_OUT(W), .N(N), .LANES(4)) dut4 (
    .clk(clk), .resetn(resetn), .valid_in(valid_in), .result(result),
    .in_ready(in_ready4), .m_valid(m_valid4), .m_data(m_data4), .m_last(m_last4),
    .m_ready(m_ready), .ovf_clr(ovf_clr), .overflow(overflow4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: elements still owed downstream per instance, plus the sticky flag.
  int mq[2][$];
  bit ovf_m[2];
  int lanes_of[2] = '{1, 4};
  int cur[E];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive the result bus: 0 -> k+1, 1 -> -k, 2 -> 100+k, else random.
  task automatic fill(input int mode);
    for (int k = 0; k < E; k++) begin
      case (mode)
        0:       cur[k] = k + 1;
        1:       cur[k] = -k;
        2:       cur[k] = 100 + k;
        default: cur[k] = int'($urandom);
      endcase
      result[k*W +: W] = cur[k];
    end
  endtask

  task automatic check_outputs();
    logic         ir, mv, ml, ov;
    logic [127:0] md, exp_md;
    int           sz, l;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        ir = in_ready1; mv = m_valid1; ml = m_last1; ov = overflow1; md = 128'(m_data1);
      end else begin
        ir = in_ready4; mv = m_valid4; ml = m_last4; ov = overflow4; md = 128'(m_data4);
      end
      sz = mq[i].size();
      l  = lanes_of[i];
      check($sformatf("m_valid_L%0d", l), mv, sz > 0);
      check($sformatf("m_last_L%0d", l), ml, sz == l);
      check($sformatf("in_ready_L%0d", l), ir, (sz == 0) || (m_ready && sz == l));
      check($sformatf("overflow_L%0d", l), ov, ovf_m[i]);
      if (sz > 0) begin
        exp_md = '0;
        for (int j = 0; j < l; j++) exp_md[j*W +: W] = mq[i][j];
        check($sformatf("m_data_L%0d", l), md, exp_md);
      end
    end
  endtask

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int  sz, l;
    bit  hs, rdy_in;
    for (int i = 0; i < 2; i++) begin
      sz     = mq[i].size();
      l      = lanes_of[i];
      hs     = (sz > 0) && m_ready;
      rdy_in = (sz == 0) || (hs && sz == l);
      if (hs) repeat (l) void'(mq[i].pop_front());
      if (valid_in && rdy_in) for (int k = 0; k < E; k++) mq[i].push_back(cur[k]);
      if (valid_in && !rdy_in) ovf_m[i] = 1'b1;
      else if (ovf_clr)        ovf_m[i] = 1'b0;
    end
  endtask

  // One cycle: drive inputs, check mid-cycle, advance model on the edge.
  task automatic step(input bit v, input bit rdy, input bit clr, input int mode);
    valid_in = v;
    m_ready  = rdy;
    ovf_clr  = clr;
    fill(v ? mode : 3);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    valid_in = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  // Run until both instances are idle; pat 1 uses the 1,0,0 ready pattern.
  task automatic drain(input int pat, input int mode);
    int i;
    i = 0;
    while ((mq[0].size() != 0 || mq[1].size() != 0) && i < 1000) begin
      step(1'b0, (pat == 0) ? 1'b1 : (i % 3 == 0), 1'b0, mode);
      i++;
    end
    check("drain_budget", i < 1000, 1'b1);
  endtask

  initial begin
    // Reset values.
    #12;
    check("rst_m_valid1", m_valid1, 1'b0);
    check("rst_m_valid4", m_valid4, 1'b0);
    check("rst_m_last1", m_last1, 1'b0);
    check("rst_overflow1", overflow1, 1'b0);
    check("rst_in_ready1", in_ready1, 1'b1);
    check("rst_m_data1", 128'(m_data1), 128'd0);
    check("rst_m_data4", 128'(m_data4), 128'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    step(1'b0, 1'b1, 1'b0, 3);

    // Full-throughput drain of 1..64.
    step(1'b1, 1'b1, 1'b0, 0);
    drain(0, 3);

    // Backpressure with negative elements.
    step(1'b1, 1'b1, 1'b0, 1);
    drain(1, 3);

    // Back-to-back: new matrix offered in the last-beat handshake cycle.
    step(1'b1, 1'b1, 1'b0, 0);
    while (mq[0].size() > 1) step(1'b0, 1'b1, 1'b0, 3);
    step(1'b1, 1'b1, 1'b0, 2);
    drain(0, 3);

    // Overflow: drop at beat 10, clear, then drop together with clear.
    step(1'b1, 1'b1, 1'b0, 0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 3);
    step(1'b1, 1'b1, 1'b0, 3);
    step(1'b0, 1'b1, 1'b0, 3);
    step(1'b0, 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 1'b0, 3);
    step(1'b1, 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 1'b0, 3);
    drain(0, 3);

    // Asynchronous reset in the middle of a stream.
    step(1'b1, 1'b1, 1'b0, 0);
    repeat (20) step(1'b0, 1'b1, 1'b0, 3);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_m_valid1", m_valid1, 1'b0);
    check("async_rst_m_valid4", m_valid4, 1'b0);
    check("async_rst_in_ready1", in_ready1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      ovf_m[i] = 1'b0;
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    step(1'b1, 1'b1, 1'b0, 0);
    drain(0, 3);

    // Randomized traffic.
    repeat (1500) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, 3);
    end
    drain(0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
